// File: rtl/dflow_pkg.sv
// Shared types and sizing helpers for the dflow replay engine.
// State encoding, record field offsets and counter width functions.
package dflow_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE,
        ST_FLUSH
    } state_t;

    // Tuple always sits at the bottom of a stored record.
    localparam int TUPLE_LSB = 0;

    function automatic int len_lsb(input int tuple_width);
        return tuple_width;
    endfunction

    function automatic int len_msb(input int tuple_width, input int len_width);
        return tuple_width + len_width - 1;
    endfunction

    // Pointer width into a power-of-2 buffer.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy counters must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dflow_sync_fifo.sv
// First-word-fall-through return buffer with synchronous clear.
// Ports: clk, resetn, clr, wr_en/wr_data, rd_en/rd_data, empty, full, count.
module dflow_sync_fifo
    import dflow_pkg::*;
#(
    parameter int WIDTH = 120,
    parameter int DEPTH = 8,
    localparam int PW = ptr_width(DEPTH),
    localparam int CW = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    // Credit accounting upstream keeps writes away from a full buffer.
    wr_overflow: assert property (
        @(posedge clk) disable iff (!resetn) !(wr_en && full && !clr)
    );

endmodule

// File: rtl/dflow_replay_engine.sv
// Replays a QDR address window of {pkt_len, tuple} records N times or forever.
// Ports: QDR read cmd/return, tuple valid/ready output, start/stop/sw_rst control, status.
module dflow_replay_engine
    import dflow_pkg::*;
#(
    parameter int TUPLE_WIDTH        = 104,
    parameter int LEN_WIDTH          = 16,
    parameter int MEM_ADDR_WIDTH     = 19,
    parameter int MEM_DATA_WIDTH     = 144,
    parameter int REPLAY_COUNT_WIDTH = 32,
    parameter int GAP_WIDTH          = 16,
    parameter int RET_DEPTH          = 8
) (
    input  logic                          qdr_clk,
    input  logic                          resetn,
    input  logic                          sw_rst,
    input  logic                          start_replay,
    input  logic                          stop_replay,
    input  logic [REPLAY_COUNT_WIDTH-1:0] replay_count,
    input  logic [GAP_WIDTH-1:0]          gap_cycles,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_low,
    input  logic [MEM_ADDR_WIDTH-1:0]     mem_addr_high,
    input  logic                          init_calib_complete,
    output logic                          user_app_rd_cmd,
    output logic [MEM_ADDR_WIDTH-1:0]     user_app_rd_addr,
    input  logic [MEM_DATA_WIDTH-1:0]     user_app_rd_data,
    input  logic                          user_app_rd_valid,
    output logic [TUPLE_WIDTH-1:0]        fivetuple_data_out,
    output logic [LEN_WIDTH-1:0]          pkt_len_out,
    output logic                          tuple_out_vld,
    input  logic                          tuple_out_ready,
    output logic                          busy,
    output logic                          compelete_replay,
    output logic [31:0]                   tuples_sent
);

    localparam int WORD_WIDTH = TUPLE_WIDTH + LEN_WIDTH;
    localparam int CW         = cnt_width(RET_DEPTH);
    localparam int LEN_LSB    = len_lsb(TUPLE_WIDTH);
    localparam int LEN_MSB    = len_msb(TUPLE_WIDTH, LEN_WIDTH);
    localparam logic [CW:0] RET_LIMIT = (CW+1)'(RET_DEPTH);

    state_t                          state;
    logic                            start_q;
    logic                            stop_q;
    logic                            start_rise;
    logic                            stop_rise;
    logic                            launch;
    logic [REPLAY_COUNT_WIDTH-1:0]   cfg_count;
    logic [REPLAY_COUNT_WIDTH-1:0]   pass_cnt;
    logic [REPLAY_COUNT_WIDTH-1:0]   pass_next;
    logic [GAP_WIDTH-1:0]            cfg_gap;
    logic [GAP_WIDTH-1:0]            gap_cnt;
    logic [MEM_ADDR_WIDTH-1:0]       cfg_low;
    logic [MEM_ADDR_WIDTH-1:0]       cfg_high;
    logic [MEM_ADDR_WIDTH-1:0]       addr;
    logic [CW-1:0]                   inflight;
    logic [CW-1:0]                   fifo_count;
    logic [CW:0]                     pending;
    logic                            credit_ok;
    logic                            rd_cmd;
    logic                            ret_dec;
    logic                            flush;
    logic                            fifo_push;
    logic                            fifo_pop;
    logic                            fifo_empty;
    logic                            unused_fifo_full;
    logic [WORD_WIDTH-1:0]           fifo_rd_data;
    logic                            handshake;
    logic                            gap_ok;

    generate
        if (MEM_DATA_WIDTH > WORD_WIDTH) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^user_app_rd_data[MEM_DATA_WIDTH-1:WORD_WIDTH];
        end
    endgenerate

    assign start_rise = start_replay && !start_q;
    assign stop_rise  = stop_replay && !stop_q;
    assign launch     = start_rise && init_calib_complete && !sw_rst &&
                        (state == ST_IDLE || state == ST_DONE);
    assign pass_next  = pass_cnt + REPLAY_COUNT_WIDTH'(1);

    // Reads in flight plus buffered words may never exceed the buffer.
    assign pending    = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok  = pending < RET_LIMIT;
    assign rd_cmd     = (state == ST_READ) && credit_ok && !sw_rst;
    assign ret_dec    = user_app_rd_valid && (inflight != '0);

    assign flush      = sw_rst || (state == ST_FLUSH);
    assign fifo_push  = ret_dec && !flush;
    assign handshake  = tuple_out_vld && tuple_out_ready;
    // Loading at count 1 leaves exactly gap_cycles idle cycles.
    assign gap_ok     = gap_cnt <= GAP_WIDTH'(1);
    assign fifo_pop   = !fifo_empty && !flush &&
                        (tuple_out_vld ? (handshake && cfg_gap == '0) : gap_ok);

    assign user_app_rd_cmd  = rd_cmd;
    assign user_app_rd_addr = addr;
    assign busy             = (state != ST_IDLE) && (state != ST_DONE);
    assign compelete_replay = (state == ST_DONE);

    dflow_sync_fifo #(
        .WIDTH (WORD_WIDTH),
        .DEPTH (RET_DEPTH)
    ) u_ret_fifo (
        .clk     (qdr_clk),
        .resetn  (resetn),
        .clr     (flush),
        .wr_en   (fifo_push),
        .wr_data (user_app_rd_data[WORD_WIDTH-1:0]),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (unused_fifo_full),
        .count   (fifo_count)
    );

    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
            cfg_count <= '0;
            cfg_gap   <= '0;
            cfg_low   <= '0;
            cfg_high  <= '0;
            addr      <= '0;
            pass_cnt  <= '0;
        end else begin
            start_q <= start_replay;
            stop_q  <= stop_replay;
            if (sw_rst) begin
                state <= ST_FLUSH;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (launch) begin
                            cfg_count <= replay_count;
                            cfg_gap   <= gap_cycles;
                            cfg_low   <= mem_addr_low;
                            cfg_high  <= mem_addr_high;
                            addr      <= mem_addr_low;
                            pass_cnt  <= '0;
                            state     <= (mem_addr_low > mem_addr_high) ?
                                         ST_DONE : ST_READ;
                        end
                    end
                    ST_READ: begin
                        if (rd_cmd) begin
                            if (addr == cfg_high) begin
                                pass_cnt <= pass_next;
                                if (cfg_count != '0 && pass_next == cfg_count) begin
                                    state <= ST_DRAIN;
                                end else begin
                                    addr <= cfg_low;
                                end
                            end else begin
                                addr <= addr + MEM_ADDR_WIDTH'(1);
                            end
                        end
                        if (stop_rise) begin
                            state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        if (inflight == '0 && fifo_empty && !tuple_out_vld) begin
                            state <= ST_DONE;
                        end
                    end
                    ST_FLUSH: begin
                        if (inflight == '0) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // Only resetn clears this; a flush must wait for every return.
    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            inflight <= '0;
        end else begin
            case ({rd_cmd, ret_dec})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge qdr_clk) begin
        if (!resetn) begin
            tuple_out_vld      <= 1'b0;
            fivetuple_data_out <= '0;
            pkt_len_out        <= '0;
            gap_cnt            <= '0;
            tuples_sent        <= '0;
        end else begin
            if (launch) begin
                tuples_sent <= '0;
            end else if (handshake) begin
                tuples_sent <= tuples_sent + 32'd1;
            end
            if (flush) begin
                tuple_out_vld      <= 1'b0;
                fivetuple_data_out <= '0;
                pkt_len_out        <= '0;
                gap_cnt            <= '0;
            end else begin
                if (fifo_pop) begin
                    tuple_out_vld      <= 1'b1;
                    fivetuple_data_out <= fifo_rd_data[TUPLE_WIDTH-1:TUPLE_LSB];
                    pkt_len_out        <= fifo_rd_data[LEN_MSB:LEN_LSB];
                end else if (handshake) begin
                    tuple_out_vld <= 1'b0;
                end
                if (handshake) begin
                    gap_cnt <= cfg_gap;
                end else if (gap_cnt != '0) begin
                    gap_cnt <= gap_cnt - GAP_WIDTH'(1);
                end
            end
        end
    end

endmodule
